// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one memory between the CPU and a DMA/loader port.
// One transaction at a time, registered memory-side outputs, acknowledge with timeout.
module mem_arbiter #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          cpu_req_i,
  input  logic [1:0]    cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_ack_o,
  output logic          cpu_err_o,
  input  logic          dma_req_i,
  input  logic [1:0]    dma_we_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_wdata_i,
  output logic [DW-1:0] dma_rdata_o,
  output logic          dma_ack_o,
  output logic          dma_err_o,
  output logic          mem_req_o,
  output logic [1:0]    mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          busy_o,
  output logic          owner_o
);

  localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle = 2'b00, StAccess = 2'b01, StDone = 2'b10} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   dma_rdata_q, dma_rdata_d;
  logic            grant_dma;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    grant_dma   = 1'b0;

    case (state_q)
      StIdle: begin
        if (cpu_req_i || dma_req_i) begin
          // On conflict the port that was not served last wins.
          grant_dma   = dma_req_i && (!cpu_req_i || !last_q);
          owner_d     = grant_dma;
          mem_we_d    = grant_dma ? dma_we_i    : cpu_we_i;
          mem_addr_d  = grant_dma ? dma_addr_i  : cpu_addr_i;
          mem_wdata_d = grant_dma ? dma_wdata_i : cpu_wdata_i;
          cnt_d       = '0;
          state_d     = StAccess;
        end
      end
      StAccess: begin
        if (mem_ack_i) begin
          if (owner_q) dma_rdata_d = mem_rdata_i;
          else         cpu_rdata_d = mem_rdata_i;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == CntMax) begin
          if (owner_q) dma_rdata_d = '0;
          else         cpu_rdata_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Outputs decode flops only, so no input reaches an output combinationally.
  assign mem_req_o   = (state_q == StAccess);
  assign busy_o      = (state_q != StIdle);
  assign owner_o     = owner_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_rdata_o = dma_rdata_q;
  assign cpu_ack_o   = (state_q == StDone) && !owner_q;
  assign dma_ack_o   = (state_q == StDone) && owner_q;
  assign cpu_err_o   = cpu_ack_o && err_q;
  assign dma_err_o   = dma_ack_o && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-timing reference model.
module tb_mem_arbiter;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, dma_req = 1'b0, mem_ack = 1'b0;
  logic [1:0]  cpu_we = '0, dma_we = '0;
  logic [31:0] cpu_addr = '0, dma_addr = '0, cpu_wdata = '0, dma_wdata = '0, mem_rdata = '0;
  logic [31:0] cpu_rdata_o, dma_rdata_o, mem_addr_o, mem_wdata_o;
  logic [1:0]  mem_we_o;
  logic        cpu_ack_o, cpu_err_o, dma_ack_o, dma_err_o, mem_req_o, busy_o, owner_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DW(32), .AW(32), .TIMEOUT(T)) dut (
    .clk_i(clk), .reset_i(reset),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata_o), .cpu_ack_o(cpu_ack_o), .cpu_err_o(cpu_err_o),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_rdata_o(dma_rdata_o), .dma_ack_o(dma_ack_o), .dma_err_o(dma_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  typedef struct {
    logic [1:0]  req;        // bit0 CPU, bit1 DMA
    logic [1:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;      // access cycle index carrying mem_ack; 99 = never
    logic [31:0] rd;
    logic        exp_owner;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_acc;    // cycles with mem_req high
  } vec_t;

  typedef struct {
    logic [1:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tx_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_req"}, mem_req_o, 0);
    chk({tag, " busy"}, busy_o, 0);
    chk({tag, " owner"}, owner_o, 0);
    chk({tag, " mem_we"}, mem_we_o, 0);
    chk({tag, " mem_addr"}, mem_addr_o, 0);
    chk({tag, " mem_wdata"}, mem_wdata_o, 0);
    chk({tag, " acks"}, {cpu_ack_o, dma_ack_o}, 0);
    chk({tag, " errs"}, {cpu_err_o, dma_err_o}, 0);
    chk({tag, " cpu_rdata"}, cpu_rdata_o, 0);
    chk({tag, " dma_rdata"}, dma_rdata_o, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cpu_req = 0; dma_req = 0; mem_ack = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int acc, lat;
    bit done;
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(negedge clk);
    cpu_req = v.req[0];
    dma_req = v.req[1];
    // The expected winner carries the row's values, the other side carries decoys.
    if (v.exp_owner) begin
      dma_we = v.we;  dma_addr = v.addr;           dma_wdata = v.wdata;
      cpu_we = ~v.we; cpu_addr = v.addr ^ 32'h1000; cpu_wdata = ~v.wdata;
    end else begin
      cpu_we = v.we;  cpu_addr = v.addr;           cpu_wdata = v.wdata;
      dma_we = ~v.we; dma_addr = v.addr ^ 32'h1000; dma_wdata = ~v.wdata;
    end
    mem_ack = 0; mem_rdata = $urandom;
    acc = 0; lat = 0; done = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_req_o) begin
        chk({nm, " mem_addr"}, mem_addr_o, v.addr);
        chk({nm, " mem_we"}, mem_we_o, v.we);
        chk({nm, " mem_wdata"}, mem_wdata_o, v.wdata);
        chk({nm, " owner"}, owner_o, v.exp_owner);
        chk({nm, " early_ack"}, {cpu_ack_o, dma_ack_o}, 2'b00);
        cpu_addr = $urandom; dma_addr = $urandom; cpu_wdata = $urandom; dma_wdata = $urandom;
        cpu_we = 2'($urandom); dma_we = 2'($urandom);
        mem_ack = (acc == v.delay);
        mem_rdata = mem_ack ? v.rd : $urandom;
        acc++;
      end else if (cpu_ack_o || dma_ack_o) begin
        done = 1;
        chk({nm, " ack_side"}, {cpu_ack_o, dma_ack_o}, {!v.exp_owner, v.exp_owner});
        chk({nm, " ack_owner"}, owner_o, v.exp_owner);
        chk({nm, " rdata"}, v.exp_owner ? dma_rdata_o : cpu_rdata_o, v.exp_rdata);
        chk({nm, " err"}, v.exp_owner ? dma_err_o : cpu_err_o, v.exp_err);
        chk({nm, " access_cycles"}, acc, v.exp_acc);
        chk({nm, " latency"}, lat, v.exp_acc + 1);
        cpu_req = 0; dma_req = 0; mem_ack = 0;
      end else begin
        mem_ack = 0;
      end
    end
    if (!done) chk({nm, " ack_wait"}, 0, 1);
  endtask

  task automatic seq_alternate();
    int ack_t[$];
    int t;
    do_reset();
    @(negedge clk);
    cpu_req = 1; dma_req = 1; cpu_addr = 32'h10; dma_addr = 32'h20; cpu_we = 0; dma_we = 0;
    t = 0;
    while (ack_t.size() < 4 && t < 30) begin
      @(negedge clk);
      t++;
      mem_ack = mem_req_o;
      mem_rdata = 32'(t);
      if (cpu_ack_o || dma_ack_o) begin
        chk($sformatf("alt%0d owner", ack_t.size()), owner_o, ack_t.size() % 2);
        chk($sformatf("alt%0d side", ack_t.size()), {cpu_ack_o, dma_ack_o},
            (ack_t.size() % 2) ? 2'b01 : 2'b10);
        ack_t.push_back(t);
      end
    end
    cpu_req = 0; dma_req = 0; mem_ack = 0;
    chk("alt ack_count", ack_t.size(), 4);
    if (ack_t.size() > 0) chk("alt first_latency", ack_t[0], 2);
    for (int i = 1; i < ack_t.size(); i++) chk($sformatf("alt%0d spacing", i),
                                              ack_t[i] - ack_t[i-1], 3);
  endtask

  task automatic seq_reset_mid();
    int t;
    bit got;
    do_reset();
    @(negedge clk);
    cpu_req = 1; dma_req = 0; cpu_addr = 32'h80; cpu_we = 0;
    got = 0; t = 0;
    while (!got && t < 10) begin
      @(negedge clk);
      t++;
      mem_ack = mem_req_o;
      mem_rdata = 32'hFEEDF00D;
      if (cpu_ack_o) begin got = 1; cpu_req = 0; mem_ack = 0; end
    end
    chk("rst pre_ack", got, 1);
    chk("rst pre_rdata", cpu_rdata_o, 32'hFEEDF00D);
    @(negedge clk);
    cpu_req = 1; cpu_addr = 32'h84; mem_ack = 0;
    repeat (3) @(negedge clk);
    chk("rst in_access", mem_req_o, 1);
    reset = 1;
    @(negedge clk);
    chk_all_zero("rst mid");
    reset = 0; dma_req = 1; dma_addr = 32'h88;
    got = 0; t = 0;
    while (!got && t < 10) begin
      @(negedge clk);
      t++;
      mem_ack = mem_req_o;
      if (cpu_ack_o || dma_ack_o) begin
        got = 1;
        chk("rst first_side", {cpu_ack_o, dma_ack_o}, 2'b10);
        chk("rst first_owner", owner_o, 0);
      end
    end
    chk("rst post_ack", got, 1);
    cpu_req = 0; dma_req = 0; mem_ack = 0;
  endtask

  task automatic drive_side(input bit side, input tx_t tx);
    if (side) begin dma_we = tx.we; dma_addr = tx.addr; dma_wdata = tx.wdata; end
    else      begin cpu_we = tx.we; cpu_addr = tx.addr; cpu_wdata = tx.wdata; end
  endtask

  function automatic tx_t rand_tx();
    tx_t tx;
    tx.we = 2'($urandom); tx.addr = $urandom; tx.wdata = $urandom;
    return tx;
  endfunction

  // Model rules: a pending request is granted at the first edge where the arbiter is free;
  // access lasts until the acked cycle (or T+1 cycles); ack follows; one idle cycle after.
  task automatic run_random(input int n);
    tx_t cpu_t, dma_t, cur;
    bit act, w, last_w, own, s_cpu, s_dma, in_acc, in_done, e_err;
    int k, g, d, done_edge, can_grant, r;
    logic [31:0] rd, exp_cr, exp_dr;
    do_reset();
    cur = '{2'b00, 32'h0, 32'h0};
    act = 0; w = 0; last_w = 1; own = 0; k = 0; g = 0; d = 0; done_edge = 0; can_grant = 1;
    rd = '0; exp_cr = '0; exp_dr = '0; e_err = 0;
    cpu_t = rand_tx(); dma_t = rand_tx();
    for (int it = 0; it < n; it++) begin
      s_cpu = cpu_req; s_dma = dma_req;
      @(negedge clk);
      k++;
      if (!act && k >= can_grant && (s_cpu || s_dma)) begin
        w = s_dma && (!s_cpu || !last_w);
        act = 1; g = k; own = w;
        cur = w ? dma_t : cpu_t;
        r = $urandom_range(0, 11);
        d = (r == 0) ? -1 : (r == 1) ? T : r - 2;
        done_edge = (d < 0) ? g + T + 1 : g + d + 1;
      end
      in_acc  = act && (k < done_edge);
      in_done = act && (k == done_edge);
      if (in_done) begin
        e_err = (d < 0);
        if (w) exp_dr = e_err ? 32'h0 : rd;
        else   exp_cr = e_err ? 32'h0 : rd;
      end
      chk("rnd mem_req", mem_req_o, in_acc);
      chk("rnd busy", busy_o, in_acc || in_done);
      chk("rnd owner", owner_o, own);
      chk("rnd mem_bus", {mem_we_o, mem_addr_o, mem_wdata_o}, {cur.we, cur.addr, cur.wdata});
      chk("rnd acks", {cpu_ack_o, dma_ack_o}, {in_done && !w, in_done && w});
      chk("rnd errs", {cpu_err_o, dma_err_o}, {in_done && !w && e_err, in_done && w && e_err});
      chk("rnd cpu_rdata", cpu_rdata_o, exp_cr);
      chk("rnd dma_rdata", dma_rdata_o, exp_dr);
      if (in_acc) begin
        mem_ack = (d >= 0) && (k == g + d);
        mem_rdata = $urandom;
        if (mem_ack) rd = mem_rdata;
        drive_side(w, rand_tx());
      end else begin
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
      end
      if (in_done) begin
        act = 0; last_w = w; can_grant = k + 2;
        if (w) begin dma_t = rand_tx(); dma_req = 1'($urandom); end
        else   begin cpu_t = rand_tx(); cpu_req = 1'($urandom); end
        drive_side(w, w ? dma_t : cpu_t);
      end
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_t = rand_tx(); cpu_req = 1; drive_side(1'b0, cpu_t);
      end
      if (!dma_req && $urandom_range(0, 2) == 0) begin
        dma_t = rand_tx(); dma_req = 1; drive_side(1'b1, dma_t);
      end
    end
    cpu_req = 0; dma_req = 0; mem_ack = 0;
  endtask

  initial begin
    vec_t vecs [9];
    vecs[0] = '{2'b01, 2'b00, 32'h40,  32'h0,        0,  32'h12345678, 1'b0, 1'b0, 32'h12345678, 1};
    vecs[1] = '{2'b11, 2'b00, 32'h200, 32'h11111111, 0,  32'h0BADF00D, 1'b1, 1'b0, 32'h0BADF00D, 1};
    vecs[2] = '{2'b11, 2'b00, 32'h300, 32'h22222222, 1,  32'h55AA55AA, 1'b0, 1'b0, 32'h55AA55AA, 2};
    vecs[3] = '{2'b10, 2'b01, 32'h100, 32'hCAFEBABE, 4,  32'hDEAD0001, 1'b1, 1'b0, 32'hDEAD0001, 5};
    vecs[4] = '{2'b01, 2'b00, 32'h44,  32'h0,        99, 32'h0,        1'b0, 1'b1, 32'h0,        16};
    vecs[5] = '{2'b01, 2'b00, 32'h48,  32'h0,        15, 32'hA5A5A5A5, 1'b0, 1'b0, 32'hA5A5A5A5, 16};
    vecs[6] = '{2'b11, 2'b00, 32'h50,  32'h33333333, 0,  32'h01020304, 1'b1, 1'b0, 32'h01020304, 1};
    vecs[7] = '{2'b10, 2'b10, 32'h60,  32'h44444444, 2,  32'h77777777, 1'b1, 1'b0, 32'h77777777, 3};
    vecs[8] = '{2'b11, 2'b11, 32'h70,  32'h55555555, 3,  32'h89ABCDEF, 1'b0, 1'b0, 32'h89ABCDEF, 4};

    do_reset();
    chk_all_zero("reset");
    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);
    seq_alternate();
    seq_reset_mid();
    run_random(3000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified instruction/data memory of the multicycle core between the CPU and a DMA/loader port. Accepts one transaction at a time, grants round-robin on conflict, forwards it to memory with registered outputs, waits for the memory acknowledge (with timeout), and returns read data plus a one-cycle ack to the winner. The CPU-side ack drives the core's stall logic: the controller holds its state, and pcen stays low, until `cpu_ack`.

## Interface
- `DW`, 32, data width
- `AW`, 32, address width
- `TIMEOUT`, 15, max ACCESS cycles without `mem_ack` before error (≥1, counter width `$clog2(TIMEOUT+1)`)
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `cpu_req`  in  1  CPU transaction request, held until `cpu_ack`
- `cpu_we`  in  2  write type, same encoding as core `memwrite`; 00 = read
- `cpu_addr`  in  AW  CPU address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_rdata`  out  DW  read data, valid in `cpu_ack` cycle
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_err`  out  1  with `cpu_ack`: transaction timed out
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_rdata`, `dma_ack`, `dma_err`: same as CPU set, DMA side
- `mem_req`  out  1  memory access active
- `mem_we`  out  2  latched write type
- `mem_addr`  out  AW  latched address
- `mem_wdata`  out  DW  latched write data
- `mem_rdata`  in  DW  memory read data, valid with `mem_ack`
- `mem_ack`  in  1  memory completion, sampled only in ACCESS
- `busy`  out  1  state ≠ IDLE
- `owner`  out  1  0 = CPU, 1 = DMA; current/last grantee

## Operation
- States: IDLE, ACCESS, DONE. Reset → IDLE.
- IDLE: if neither req, stay. One req → grant it. Both → grant the one ≠ `last` (round-robin). On grant: latch we/addr/wdata into mem_* regs, set `owner`, clear timeout counter, go ACCESS.
- ACCESS: `mem_req`=1, mem_* held constant. Each cycle without `mem_ack`: counter+1. `mem_ack`=1 → latch `mem_rdata` into winner's rdata, err=0, go DONE. Counter == TIMEOUT with no ack → winner's rdata = 0, err=1, go DONE. Ack and timeout in same cycle: ack wins.
- DONE: winner's ack=1 (err as latched), `mem_req`=0, `last` ← `owner`, go IDLE unconditionally.
- Loser's req is ignored until a later IDLE; it must stay asserted.
- Write transactions (we≠00): rdata still updated from `mem_rdata` (memory-defined), no special casing.
- Requester inputs are ignored outside IDLE; changing them mid-transaction has no effect.
- Reset (any state, incl. mid-ACCESS): state IDLE, `mem_req`=0, mem_* = 0, both rdata = 0, acks/errs = 0, `busy`=0, `owner`=0, `last`=DMA (so CPU wins first conflict), counter = 0. The in-flight transaction is dropped without ack.

## Timing
- All outputs registered; no combinational path from any input to any output.
- Minimum latency: req seen at edge N → ACCESS in cycle N..N+1 (`mem_req`=1) → `mem_ack` in that cycle → ack in cycle N+1..N+2. Request to ack = 2 cycles + memory wait cycles.
- Requester drops or re-issues req on the edge ending its ack cycle; arbiter re-samples req in the following IDLE cycle. Minimum spacing between grants = 3 cycles.
- Timeout: ack arrives TIMEOUT+1 cycles after entering ACCESS when `mem_ack` never rises.
- `busy` is high exactly in ACCESS and DONE.

## Test plan
- Reset then CPU read addr 0x40, `mem_ack` in first ACCESS cycle with rdata 0x12345678 → `mem_req` one cycle with addr 0x40, we 00; `cpu_ack`=1, `cpu_rdata`=0x12345678, `cpu_err`=0, two cycles after req; `dma_ack` never pulses.
- Both req asserted together, mem acks immediately, both hold req → grants alternate CPU, DMA, CPU, DMA; `owner` toggles 0,1,0,1; each ack 3 cycles apart.
- DMA write we=01, addr 0x100, wdata 0xCAFEBABE, `mem_ack` delayed 4 cycles; DMA changes addr mid-access → `mem_addr` stays 0x100 for all 5 ACCESS cycles, `dma_ack` one cycle after `mem_ack`.
- CPU read, `mem_ack` held low, TIMEOUT=15 → `mem_req` high exactly 16 cycles, then `cpu_ack`=1, `cpu_err`=1, `cpu_rdata`=0.
- `mem_ack` arrives in the same cycle the counter reaches TIMEOUT → `err`=0, rdata = `mem_rdata`.
- Reset asserted during ACCESS → next cycle all outputs 0, no ack; after release, simultaneous reqs grant CPU first.
